// File: rtl/pic_pkg.sv
// Shared types and constants for the PIC priority resolver datapath.
// Holds the acknowledge FSM encoding, mode-bit positions and the rotating-priority rank helper.
package pic_pkg;

    typedef enum logic [0:0] {
        PIC_IDLE = 1'b0,
        PIC_ACK1 = 1'b1
    } pic_state_e;

    // Bit positions inside the {rotate_en, aeoi} mode vector.
    localparam int PIC_MODE_AEOI   = 0;
    localparam int PIC_MODE_ROTATE = 1;

    localparam int PIC_VEC_W = 8;

    // Distance of a level from the current highest-priority slot; 0 is the most urgent.
    function automatic int prio_rank(input int idx, input int lowest, input int n);
        return (idx + n - lowest - 1) % n;
    endfunction

endpackage

// File: rtl/pic_rotate_scan.sv
// Rotating priority scan: finds the first set request starting just above lowest_ptr,
// wrapping modulo NUM_IRQ.
module pic_rotate_scan #(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0] req,
    input  logic [IDX_W-1:0]   lowest_ptr,
    output logic               found,
    output logic [IDX_W-1:0]   index
);

    logic [IDX_W-1:0] pos_s;
    logic             hit_s;

    // Walk the levels in priority order; the first hit is kept.
    always_comb begin
        found = 1'b0;
        index = '0;
        pos_s = '0;
        hit_s = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            pos_s = IDX_W'((int'(lowest_ptr) + 1 + i) % NUM_IRQ);
            hit_s = req[pos_s] && !found;
            index = hit_s ? pos_s : index;
            found = found | req[pos_s];
        end
    end

endmodule

// File: rtl/pic_priority_resolver.sv
// Interrupt priority resolver: IRR/ISR registers, fully-nested int_o generation,
// two-pulse INTA handshake, EOI handling and priority rotation.
module pic_priority_resolver
    import pic_pkg::*;
#(
    parameter int NUM_IRQ = 8,
    parameter int IDX_W   = $clog2(NUM_IRQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 init_done,
    input  logic [NUM_IRQ-1:0]   irq,
    input  logic [NUM_IRQ-1:0]   imr,
    input  logic                 ltim,
    input  logic                 aeoi,
    input  logic                 rotate_en,
    input  logic                 eoi_valid,
    input  logic                 eoi_specific,
    input  logic [IDX_W-1:0]     eoi_level,
    input  logic                 set_prio_valid,
    input  logic                 inta_first,
    input  logic                 inta_second,
    input  logic [PIC_VEC_W-1:0] vec_base,
    output logic                 int_o,
    output logic [PIC_VEC_W-1:0] vector_o,
    output logic                 vector_valid,
    output logic                 spurious,
    output logic [NUM_IRQ-1:0]   irr_o,
    output logic [NUM_IRQ-1:0]   isr_o,
    output logic                 proto_err
);

    localparam logic [IDX_W-1:0]   PTR_RST = IDX_W'(NUM_IRQ - 1);
    localparam logic [NUM_IRQ-1:0] BIT0    = NUM_IRQ'(1);

    logic [NUM_IRQ-1:0]   irq_q_r, irr_r, isr_r;
    logic [IDX_W-1:0]     lowest_ptr_r, ack_idx_r;
    pic_state_e           state_r;
    logic                 ack_spur_r, spurious_r, int_r, vector_valid_r, proto_err_r;
    logic [PIC_VEC_W-1:0] vector_r;

    logic [NUM_IRQ-1:0]   pend_s, ack_set_s, aeoi_clr_s, eoi_clr_s, irr_next_s, isr_next_s;
    logic [IDX_W-1:0]     cand_idx_s, isr_idx_s, eoi_idx_s, ptr_next_s;
    logic                 cand_found_s, isr_found_s, first_ok_s, second_ok_s, proto_hit_s;
    logic                 eoi_hit_s, int_next_s;
    logic [1:0]           mode_s;

    assign pend_s = irr_r & ~imr;

    pic_rotate_scan #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_cand_scan (
        .req        (pend_s),
        .lowest_ptr (lowest_ptr_r),
        .found      (cand_found_s),
        .index      (cand_idx_s)
    );

    pic_rotate_scan #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_isr_scan (
        .req        (isr_r),
        .lowest_ptr (lowest_ptr_r),
        .found      (isr_found_s),
        .index      (isr_idx_s)
    );

    // Next-state decode for acknowledge, EOI, rotation and the request registers.
    always_comb begin
        mode_s      = {rotate_en, aeoi};
        first_ok_s  = inta_first && (state_r == PIC_IDLE);
        second_ok_s = inta_second && (state_r == PIC_ACK1);
        proto_hit_s = (inta_first && (state_r == PIC_ACK1)) ||
                      (inta_second && (state_r == PIC_IDLE));
        eoi_idx_s   = eoi_specific ? eoi_level : isr_idx_s;
        eoi_hit_s   = eoi_valid && isr_found_s && (int'(eoi_idx_s) < NUM_IRQ);

        if (first_ok_s && cand_found_s) begin
            ack_set_s = BIT0 << cand_idx_s;
        end else begin
            ack_set_s = '0;
        end

        if (second_ok_s && mode_s[PIC_MODE_AEOI] && !ack_spur_r) begin
            aeoi_clr_s = BIT0 << ack_idx_r;
        end else begin
            aeoi_clr_s = '0;
        end

        if (eoi_hit_s) begin
            eoi_clr_s = BIT0 << eoi_idx_s;
        end else begin
            eoi_clr_s = '0;
        end

        // An explicit EOI outranks AEOI rotation, which outranks set-priority.
        if (eoi_hit_s && mode_s[PIC_MODE_ROTATE]) begin
            ptr_next_s = eoi_idx_s;
        end else if ((aeoi_clr_s != '0) && mode_s[PIC_MODE_ROTATE]) begin
            ptr_next_s = ack_idx_r;
        end else if (set_prio_valid && !eoi_valid && (int'(eoi_level) < NUM_IRQ)) begin
            ptr_next_s = eoi_level;
        end else begin
            ptr_next_s = lowest_ptr_r;
        end

        // Level mode follows the pin; edge mode latches rises and a new rise beats an ack clear.
        if (ltim) begin
            irr_next_s = irq;
        end else begin
            irr_next_s = (irr_r & ~ack_set_s) | (irq & ~irq_q_r);
        end

        isr_next_s = (isr_r & ~(eoi_clr_s | aeoi_clr_s)) | ack_set_s;

        int_next_s = cand_found_s &&
                     (!isr_found_s ||
                      (prio_rank(int'(cand_idx_s), int'(lowest_ptr_r), NUM_IRQ) <
                       prio_rank(int'(isr_idx_s), int'(lowest_ptr_r), NUM_IRQ)));
    end

    // Request, in-service and priority-pointer registers plus the CPU interrupt line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q_r      <= '0;
            irr_r        <= '0;
            isr_r        <= '0;
            lowest_ptr_r <= PTR_RST;
            int_r        <= 1'b0;
        end else if (!init_done) begin
            irq_q_r      <= irq;
            irr_r        <= '0;
            isr_r        <= '0;
            lowest_ptr_r <= PTR_RST;
            int_r        <= 1'b0;
        end else begin
            irq_q_r      <= irq;
            irr_r        <= irr_next_s;
            isr_r        <= isr_next_s;
            lowest_ptr_r <= ptr_next_s;
            int_r        <= int_next_s;
        end
    end

    // INTA handshake FSM, vector strobe and sticky sequence error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= PIC_IDLE;
            ack_idx_r      <= '0;
            ack_spur_r     <= 1'b0;
            spurious_r     <= 1'b0;
            vector_r       <= '0;
            vector_valid_r <= 1'b0;
            proto_err_r    <= 1'b0;
        end else if (!init_done) begin
            state_r        <= PIC_IDLE;
            vector_valid_r <= 1'b0;
        end else begin
            vector_valid_r <= second_ok_s;
            proto_err_r    <= proto_err_r | proto_hit_s;
            if (first_ok_s) begin
                state_r    <= PIC_ACK1;
                ack_idx_r  <= cand_found_s ? cand_idx_s : PTR_RST;
                ack_spur_r <= !cand_found_s;
                spurious_r <= !cand_found_s;
            end else if (second_ok_s) begin
                state_r  <= PIC_IDLE;
                vector_r <= {vec_base[PIC_VEC_W-1:IDX_W], ack_idx_r};
            end
        end
    end

    assign int_o        = int_r;
    assign vector_o     = vector_r;
    assign vector_valid = vector_valid_r;
    assign spurious     = spurious_r;
    assign irr_o        = irr_r;
    assign isr_o        = isr_r;
    assign proto_err    = proto_err_r;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Directed bench for pic_priority_resolver: expected vectors go into a scoreboard queue
// that a negedge monitor drains on every vector_valid strobe.
module tb_pic_priority_resolver;

    localparam int NUM_IRQ = 8;
    localparam int IDX_W   = 3;

    logic               clk = 1'b0;
    logic               rst_n, init_done;
    logic [NUM_IRQ-1:0] irq, imr;
    logic               ltim, aeoi, rotate_en, eoi_valid, eoi_specific;
    logic [IDX_W-1:0]   eoi_level;
    logic               set_prio_valid, inta_first, inta_second;
    logic [7:0]         vec_base;
    logic               int_o, vector_valid, spurious, proto_err;
    logic [7:0]         vector_o;
    logic [NUM_IRQ-1:0] irr_o, isr_o;

    int         pass_cnt  = 0;
    int         total_cnt = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;

    pic_priority_resolver #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .init_done(init_done), .irq(irq), .imr(imr),
        .ltim(ltim), .aeoi(aeoi), .rotate_en(rotate_en), .eoi_valid(eoi_valid),
        .eoi_specific(eoi_specific), .eoi_level(eoi_level),
        .set_prio_valid(set_prio_valid), .inta_first(inta_first),
        .inta_second(inta_second), .vec_base(vec_base), .int_o(int_o),
        .vector_o(vector_o), .vector_valid(vector_valid), .spurious(spurious),
        .irr_o(irr_o), .isr_o(isr_o), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard monitor: every vector strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (vector_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_vector: got %0h expected no strobe", vector_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("vector", 32'(vector_o), 32'(mon_e[7:0]));
                check("vector_spurious", 32'(spurious), 32'(mon_e[8]));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic inta_pair(input logic [7:0] v, input logic s);
        exp_q.push_back({s, v});
        inta_first = 1'b1;
        @(negedge clk);
        inta_first  = 1'b0;
        inta_second = 1'b1;
        @(negedge clk);
        inta_second = 1'b0;
    endtask

    task automatic eoi(input logic specific, input logic [IDX_W-1:0] lvl);
        eoi_valid = 1'b1; eoi_specific = specific; eoi_level = lvl;
        @(negedge clk);
        eoi_valid = 1'b0; eoi_specific = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_int"}, 32'(int_o), 32'h0);
        check({tag, "_vector"}, 32'(vector_o), 32'h0);
        check({tag, "_vvalid"}, 32'(vector_valid), 32'h0);
        check({tag, "_spurious"}, 32'(spurious), 32'h0);
        check({tag, "_irr"}, 32'(irr_o), 32'h0);
        check({tag, "_isr"}, 32'(isr_o), 32'h0);
        check({tag, "_proto"}, 32'(proto_err), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; init_done = 1'b1; irq = 8'h00; imr = 8'h00; ltim = 1'b0;
        aeoi = 1'b0; rotate_en = 1'b0; eoi_valid = 1'b0; eoi_specific = 1'b0;
        eoi_level = 3'd0; set_prio_valid = 1'b0; inta_first = 1'b0; inta_second = 1'b0;
        vec_base = 8'h40;
        #3;
        check_all_zero("reset");
        step(2);
        rst_n = 1'b1;
        step(1);

        // 1: two simultaneous edges, nested blocking, non-specific EOI
        irq = 8'h28;
        step(1);
        check("s1_irr", 32'(irr_o), 32'h28);
        check("s1_int_early", 32'(int_o), 32'h0);
        step(1);
        check("s1_int", 32'(int_o), 32'h1);
        inta_pair(8'h43, 1'b0);
        check("s1_isr", 32'(isr_o), 32'h08);
        check("s1_irr_after", 32'(irr_o), 32'h20);
        check("s1_int_nested", 32'(int_o), 32'h0);
        eoi(1'b0, 3'd0);
        check("s1_isr_eoi", 32'(isr_o), 32'h00);
        step(1);
        check("s1_int_reeval", 32'(int_o), 32'h1);
        inta_pair(8'h45, 1'b0);
        check("s1_isr2", 32'(isr_o), 32'h20);

        // 2: higher level nests over ISR5, lower level waits for EOI
        irq = 8'h2C;
        step(2);
        check("s2_int_high", 32'(int_o), 32'h1);
        inta_pair(8'h42, 1'b0);
        check("s2_isr", 32'(isr_o), 32'h24);
        eoi(1'b0, 3'd0);
        check("s2_isr_eoi", 32'(isr_o), 32'h20);
        irq = 8'h6C;
        step(2);
        check("s2_irr6", 32'(irr_o), 32'h40);
        check("s2_int_low", 32'(int_o), 32'h0);
        eoi(1'b0, 3'd0);
        step(1);
        check("s2_int_after_eoi", 32'(int_o), 32'h1);
        inta_pair(8'h46, 1'b0);
        eoi(1'b0, 3'd0);
        check("s2_isr_clear", 32'(isr_o), 32'h00);
        irq = 8'h00;
        step(1);

        // 3: automatic EOI with rotation
        rotate_en = 1'b1; aeoi = 1'b1;
        irq = 8'h04;
        step(2);
        inta_pair(8'h42, 1'b0);
        check("s3_isr_aeoi", 32'(isr_o), 32'h00);
        irq = 8'h16;
        step(2);
        inta_pair(8'h44, 1'b0);
        step(1);
        inta_pair(8'h41, 1'b0);
        rotate_en = 1'b0; aeoi = 1'b0;
        set_prio_valid = 1'b1; eoi_level = 3'd7;
        step(1);
        set_prio_valid = 1'b0;

        // 4: set-priority restore, specific EOI, spurious acknowledge
        irq = 8'h81;
        step(2);
        inta_pair(8'h40, 1'b0);
        inta_pair(8'h47, 1'b0);
        check("s4_isr_both", 32'(isr_o), 32'h81);
        eoi(1'b1, 3'd7);
        check("s4_isr_specific", 32'(isr_o), 32'h01);
        aeoi = 1'b1;
        inta_pair(8'h47, 1'b1);
        check("s4_spurious", 32'(spurious), 32'h1);
        check("s4_isr_kept", 32'(isr_o), 32'h01);
        aeoi = 1'b0;
        eoi(1'b0, 3'd0);
        check("s4_isr_final", 32'(isr_o), 32'h00);

        // 5: masked request
        irq = 8'h00;
        step(1);
        imr = 8'h08; irq = 8'h08;
        step(2);
        check("s5_irr", 32'(irr_o), 32'h08);
        check("s5_int_masked", 32'(int_o), 32'h0);
        imr = 8'h00;
        step(1);
        check("s5_int_unmasked", 32'(int_o), 32'h1);
        inta_pair(8'h43, 1'b0);
        check("s5_spurious_clr", 32'(spurious), 32'h0);
        eoi(1'b0, 3'd0);
        irq = 8'h00;
        step(1);

        // 6: reset mid-handshake, protocol error, reset priority
        check("s6_proto_before", 32'(proto_err), 32'h0);
        irq = 8'h02;
        step(2);
        inta_first = 1'b1;
        step(1);
        inta_first = 1'b0;
        check("s6_isr_pre", 32'(isr_o), 32'h02);
        #2 rst_n = 1'b0;
        inta_second = 1'b1;
        irq = 8'h00;
        #1;
        check_all_zero("s6_reset");
        step(1);
        inta_second = 1'b0;
        rst_n = 1'b1;
        step(1);
        check("s6_no_vvalid", 32'(vector_valid), 32'h0);
        inta_second = 1'b1;
        step(1);
        inta_second = 1'b0;
        check("s6_proto_err", 32'(proto_err), 32'h1);
        irq = 8'h81;
        step(2);
        inta_pair(8'h40, 1'b0);

        // level-triggered request follows the pin
        ltim = 1'b1; irq = 8'h40;
        step(1);
        check("lvl_irr_set", 32'(irr_o), 32'h40);
        irq = 8'h00;
        step(1);
        check("lvl_irr_drop", 32'(irr_o), 32'h00);
        step(2);

        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
